// File: rtl/hazard_ctl_if.sv
// Decode/execute/memory hazard signals exchanged between the pipeline and
// the interlock controller.
interface hazard_ctl_if #(
    parameter int CPU_REGNO_WIDTH = 5
);
    logic [CPU_REGNO_WIDTH-1:0] rs;
    logic [CPU_REGNO_WIDTH-1:0] rt;
    logic                       use_rs;
    logic                       use_rt;
    logic                       md_use_p1;
    logic [CPU_REGNO_WIDTH-1:0] rd_p2;
    logic                       load_p2;
    logic                       md_start;
    logic                       md_div;
    logic                       mem_busy;
    logic                       stall_p0;
    logic                       stall_p1;
    logic                       stall_p2;
    logic                       stall_p3;
    logic                       bubble_p2;
    logic                       md_busy;
    logic                       md_done;

    modport master (
        output rs, rt, use_rs, use_rt, md_use_p1, rd_p2, load_p2,
               md_start, md_div, mem_busy,
        input  stall_p0, stall_p1, stall_p2, stall_p3, bubble_p2,
               md_busy, md_done
    );

    modport slave (
        input  rs, rt, use_rs, use_rt, md_use_p1, rd_p2, load_p2,
               md_start, md_div, mem_busy,
        output stall_p0, stall_p1, stall_p2, stall_p3, bubble_p2,
               md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline interlock: load-use, bus-wait and mul/div-busy stalls, plus the
// mul/div latency counter that tells decode when HI/LO are valid.
module hazard_ctl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic         clk,
    input  logic         nrst,
    hazard_ctl_if.slave  hz
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;
    logic             md_busy;
    logic             md_acc;
    logic [1:0]       src_hit;
    logic             load_use;
    logic             md_wait;
    logic [3:0]       stall;
    logic             bubble;

    assign md_busy = (cnt_q != '0);
    assign md_acc  = hz.md_start & ~hz.mem_busy & ~md_busy;

    // Latency counter keeps running through stalls; only acceptance is frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (md_acc) begin
            cnt_d = hz.md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (md_busy) begin
            cnt_d = cnt_q - 1'b1;
        end
        md_done_d = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign src_hit[0] = hz.use_rs & (hz.rs == hz.rd_p2);
    assign src_hit[1] = hz.use_rt & (hz.rt == hz.rd_p2);
    // r0 is hardwired zero, so a load "into" it never produces data to wait on.
    assign load_use   = hz.load_p2 & (hz.rd_p2 != '0) & (|src_hit);
    assign md_wait    = hz.md_use_p1 & md_busy;

    // Priority: bus wait freezes everything, otherwise hold fetch/decode and bubble.
    always_comb begin
        stall  = 4'b0000;
        bubble = 1'b0;
        if (nrst) begin
            if (hz.mem_busy) begin
                stall = 4'b1111;
            end else if (load_use | md_wait) begin
                stall  = 4'b0011;
                bubble = 1'b1;
            end
        end
    end

    assign hz.stall_p0  = stall[0];
    assign hz.stall_p1  = stall[1];
    assign hz.stall_p2  = stall[2];
    assign hz.stall_p3  = stall[3];
    assign hz.bubble_p2 = bubble;
    assign hz.md_busy   = md_busy;
    assign hz.md_done   = md_done_q;
endmodule
